dm_responder: RTL and testbench

- Data-memory responder: the target end of the CPU's load/store request interface.
- Accepts word load/store requests from the pipeline's memory stage and holds them for a programmable number of wait states.
- Returns read data or commits byte-masked writes, with a one-cycle ready strobe.
- Sits between the mips core's memory-access port and the system bus; backs the data segment in simulation and on FPGA.

---
 rtl/dm_responder.sv | 136 +++++++++++++
 tb/tb_dm_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// Data-memory responder: load/store target with programmable wait states.
// Byte-masked stores commit on entry to RESP; ready is a one-cycle strobe.
module dm_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0]  WC    = WAIT_CYCLES[3:0];

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state, state_n;
    logic [3:0]              cnt, cnt_n;
    logic [31:0]             addr_q, wdata_q;
    logic                    we_q;
    logic [3:0]              be_q;
    logic [31:0]             mem [DEPTH];
    logic [31:0]             c_addr, c_wdata;
    logic                    c_we;
    logic [3:0]              c_be;
    logic                    c_err;
    logic                    enter_resp;
    logic                    err_q;
    logic [31:0]             rdata_q;
    logic [ADDR_WIDTH-1:0]   idx;

    // Current request: live inputs in IDLE (zero-wait path), latched copy otherwise
    always_comb begin
        c_addr  = addr_q;
        c_wdata = wdata_q;
        c_we    = we_q;
        c_be    = be_q;
        if (state == IDLE) begin
            c_addr  = addr;
            c_wdata = wdata;
            c_we    = we;
            c_be    = be;
        end
        c_err = (c_addr[1:0] != 2'b00) ||
                ((c_addr >> (ADDR_WIDTH + 2)) != 32'd0);
        idx   = c_addr[ADDR_WIDTH+1:2];
    end

    // Next-state and wait counter
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        enter_resp = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (WC == 4'd0) begin
                        state_n    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = WC;
                    end
                end
            end
            WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_n    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, request latch and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == IDLE && req) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                we_q    <= we;
                be_q    <= be;
            end
            if (enter_resp) begin
                err_q   <= c_err;
                rdata_q <= (!c_we && !c_err) ? mem[idx] : 32'd0;
            end else if (state == RESP) begin
                err_q   <= 1'b0;
                rdata_q <= 32'd0;
            end
        end
    end

    // Memory array: cleared on reset, byte-masked store on entry to RESP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= 32'd0;
            end
        end else if (enter_resp && c_we && !c_err) begin
            for (int b = 0; b < 4; b++) begin
                if (c_be[b]) begin
                    mem[idx][8*b +: 8] <= c_wdata[8*b +: 8];
                end
            end
        end
    end

    assign ready = (state == RESP);
    assign err   = err_q & ready;
    assign busy  = (state != IDLE);
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed vector table, reset and zero-wait
// sequences, then random traffic against a word-array reference model.
module tb_dm_responder;

    localparam int WC = 2;

    logic        clk;
    logic        reset;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ready, err, busy;

    logic        req0, we0;
    logic [31:0] addr0, wdata0;
    logic [3:0]  be0;
    logic [31:0] rdata0;
    logic        ready0, err0, busy0;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [1024];

    dm_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .be(be), .rdata(rdata), .ready(ready),
        .err(err), .busy(busy)
    );

    dm_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0),
        .wdata(wdata0), .be(be0), .rdata(rdata0), .ready(ready0),
        .err(err0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic model_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
    endfunction

    // Apply the same transaction to the reference model; returns expected results
    task automatic model_txn(input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] b,
                             output logic [31:0] rd, output logic e);
        logic [31:0] word;
        e  = model_err(a);
        rd = 32'd0;
        if (!e) begin
            word = model[a[11:2]];
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) word[8*i +: 8] = d[8*i +: 8];
                model[a[11:2]] = word;
            end else begin
                rd = word;
            end
        end
    endtask

    // One transaction on the WAIT_CYCLES=2 instance; scrambles inputs while waiting
    task automatic txn(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       output logic [31:0] rd, output logic e);
        int lat;
        bit seen;
        @(negedge clk);
        check("idle_ready", {31'd0, ready}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_rdata", rdata, 32'd0);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(posedge clk);
        seen = 0;
        lat  = 0;
        rd   = 32'hxxxx_xxxx;
        e    = 1'bx;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            check("busy_inflight", {31'd0, busy}, 32'd1);
            if (ready) begin
                seen = 1;
                rd   = rdata;
                e    = err;
                req  = 1'b0;
            end else begin
                check("err_outside_resp", {31'd0, err}, 32'd0);
                we    = $urandom;
                addr  = $urandom;
                wdata = $urandom;
                be    = $urandom;
            end
        end
        check("latency", lat, WC + 1);
    endtask

    vec_t vecs [12];

    initial begin
        logic [31:0] rd, mrd;
        logic        e, me;
        logic        rw;
        logic [31:0] ra, rdd;
        logic [3:0]  rb;
        bit          hit;

        reset = 1'b0;
        req = 0; we = 0; addr = 0; wdata = 0; be = 0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; be0 = 0;
        for (int i = 0; i < 1024; i++) model[i] = 32'd0;

        vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h20,   32'h11223344, 4'hF, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 32'h20,   32'h0,        4'hF, 32'h11BB33DD, 1'b0};
        vecs[5]  = '{1'b1, 32'h20,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        vecs[7]  = '{1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 32'h13,   32'h0,        4'hF, 32'h0,        1'b1};
        vecs[9]  = '{1'b1, 32'h1000, 32'h55555555, 4'hF, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 32'h0,    32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
        vecs[11] = '{1'b0, 32'hFFC,  32'h0,        4'hF, 32'h0,        1'b0};

        #12;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].b, rd, e);
            model_txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].b, mrd, me);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
        end

        // Reset during WAIT: store must be dropped and outputs fall at once
        @(negedge clk);
        req = 1; we = 1; addr = 32'h40; wdata = 32'h12345678; be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req = 0;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_ready", {31'd0, ready}, 32'd0);
        for (int i = 0; i < 1024; i++) model[i] = 32'd0;
        hit = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ready) hit = 1;
        end
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ready) hit = 1;
        end
        check("no_ready_after_rst", {31'd0, hit}, 32'd0);
        txn(1'b0, 32'h40, 32'h0, 4'hF, rd, e);
        check("rst_discard_store", rd, 32'd0);
        txn(1'b0, 32'h10, 32'h0, 4'hF, rd, e);
        check("rst_clears_mem", rd, 32'd0);

        // Zero-wait instance, req held high: store then load, strobes 2 apart
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 32'h0; wdata0 = 32'h1; be0 = 4'hF;
        @(negedge clk);
        check("b2b_ready1", {31'd0, ready0}, 32'd1);
        check("b2b_err1", {31'd0, err0}, 32'd0);
        check("b2b_store_rdata", rdata0, 32'd0);
        we0 = 0; wdata0 = 32'h0;
        @(negedge clk);
        check("b2b_gap", {31'd0, ready0}, 32'd0);
        check("b2b_gap_busy", {31'd0, busy0}, 32'd0);
        @(negedge clk);
        check("b2b_ready2", {31'd0, ready0}, 32'd1);
        check("b2b_load", rdata0, 32'd1);
        req0 = 0;
        @(negedge clk);
        check("b2b_idle", {31'd0, ready0}, 32'd0);

        // Random traffic against the reference model
        for (int n = 0; n < 200; n++) begin
            rw  = $urandom;
            rdd = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 9) == 0) ra = $urandom;
            else ra = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            txn(rw, ra, rdd, rb, rd, e);
            model_txn(rw, ra, rdd, rb, mrd, me);
            check("rand_rdata", rd, mrd);
            check("rand_err", {31'd0, e}, {31'd0, me});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
